// File: rtl/arm_pkg.sv
// Shared NZCV bit positions and exception FSM state type
// for the status register slice.
package arm_pkg;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic {
    NORM = 1'b0,
    EXC  = 1'b1
  } exc_state_t;

endpackage

// File: rtl/flag_pending_counter.sv
// Up/down saturating count of in-flight flag-setting instructions,
// with synchronous clear and full/empty status.
module flag_pending_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] nxt;

  assign full  = (cnt == W'(MAX));
  assign empty = (cnt == '0);

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      (inc & ~dec & ~full):  nxt = cnt + W'(1);
      (dec & ~inc & ~empty): nxt = cnt - W'(1);
      default: ;
    endcase
    // clear wins over any same-cycle inc/dec
    if (clr) nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt;
  end

endmodule

// File: rtl/status_reg_unit.sv
// Architectural NZCV register with one-deep exception shadow
// and ID stall on stale flags.
module status_reg_unit
  import arm_pkg::*;
#(
  parameter int         MAX_PENDING = 3,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic       id_s,
  input  logic       id_uses_cond,
  output logic       stall_flags,
  input  logic       wb_valid,
  input  logic       wb_s,
  input  logic       wb_cond_pass,
  input  logic [3:0] wb_flags,
  input  logic       flush,
  input  logic       exc_enter,
  input  logic       exc_return,
  output logic [3:0] status,
  output logic [3:0] shadow,
  output logic       in_exc,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
  output logic       err_underflow
);

  localparam int W = $clog2(MAX_PENDING + 1);

  exc_state_t state, state_nxt;
  logic       issue, retire;
  logic       full, empty;
  logic       do_enter, do_return;
  logic [3:0] next_status;

  assign stall_flags = id_valid &
    ((id_uses_cond & ~empty) | (id_s & full));

  assign issue  = id_valid & id_s & ~stall_flags;
  assign retire = wb_valid & wb_s;

  assign next_status =
    (retire & wb_cond_pass) ? wb_flags : status;

  flag_pending_counter #(
    .MAX (MAX_PENDING),
    .W   (W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (issue),
    .dec   (retire),
    .clr   (flush),
    .cnt   (pending_cnt),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    do_enter  = 1'b0;
    do_return = 1'b0;
    unique case (state)
      NORM: if (exc_enter) begin
        state_nxt = EXC;
        do_enter  = 1'b1;
      end
      EXC: if (exc_return) begin
        state_nxt = NORM;
        do_return = 1'b1;
      end
      default: state_nxt = NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= NORM;
    else        state <= state_nxt;
  end

  assign in_exc = (state == EXC);

  // restore from shadow overrides a same-cycle flag commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status        <= RESET_FLAGS;
      shadow        <= 4'b0000;
      err_underflow <= 1'b0;
    end else begin
      status <= do_return ? shadow : next_status;
      if (do_enter)        shadow        <= next_status;
      if (retire & empty)  err_underflow <= 1'b1;
    end
  end

endmodule
